// File: rtl/ext_pipe_if.sv
// ext_pipe_if: producer/consumer handshake bundle for ext_pipe.
//   in_valid/in_ready/in_imm/in_op      : immediate offer from producer
//   out_valid/out_ready/out_data/out_err: extended result to consumer
// Modports: master = surrounding logic (drives offers, takes results),
//           slave  = ext_pipe itself.
interface ext_pipe_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_err;

   modport master (
      output in_valid, in_imm, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_imm, in_op, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: immediate-extension unit with a small in-order result buffer.
// Each accepted immediate is extended according to in_op and stored at the
// buffer tail; the consumer reads results from the head in acceptance order.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   flush   : synchronous buffer clear (err_cnt is preserved)
//   bus     : ext_pipe_if slave modport (input offer + output result)
//   err_cnt : saturating count of accepted illegal ops
module ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   ext_pipe_if.slave  bus,
   output logic [7:0] err_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Result word is {err, data}; illegal ops yield data 0 with err set.
   function automatic logic [OUT_W:0] ext_fn(input logic [IN_W-1:0] imm,
                                             input logic [2:0]      op);
      logic [OUT_W-1:0] sext;
      logic [OUT_W:0]   res;
      sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      case (op)
         3'b000:  res = {1'b0, {(OUT_W-IN_W){1'b0}}, imm};
         3'b001:  res = {1'b0, sext};
         3'b010:  res = {1'b0, imm, {(OUT_W-IN_W){1'b0}}};
         3'b011:  res = {1'b0, sext[OUT_W-3:0], 2'b00};
         3'b100:  res = {1'b0, {(OUT_W-8){imm[7]}}, imm[7:0]};
         3'b101:  res = {1'b0, {(OUT_W-8){1'b0}}, imm[7:0]};
         default: res = {1'b1, {OUT_W{1'b0}}};
      endcase
      return res;
   endfunction

   logic [CNT_W-1:0] count_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [7:0]       err_cnt_r;
   logic [OUT_W:0]   mem_r [DEPTH];

   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             empty_s;
   logic [OUT_W:0]   ext_s;
   logic [OUT_W:0]   head_s;

   // Handshake qualification and extension of the offered immediate.
   always_comb begin
      full_s  = (count_r >= DEPTH_C);
      empty_s = (count_r == {CNT_W{1'b0}});
      push_s  = bus.in_valid && !full_s;
      pop_s   = bus.out_ready && !empty_s;
      ext_s   = ext_fn(bus.in_imm, bus.in_op);
      head_s  = mem_r[rd_ptr_r];
   end

   // Outputs come only from state; data is forced to zero while empty.
   always_comb begin
      bus.in_ready  = !full_s;
      bus.out_valid = !empty_s;
      if (empty_s) begin
         bus.out_data = {OUT_W{1'b0}};
         bus.out_err  = 1'b0;
      end else begin
         bus.out_data = head_s[OUT_W-1:0];
         bus.out_err  = head_s[OUT_W];
      end
      err_cnt = err_cnt_r;
   end

   // Buffer storage; unoccupied entries are never observed, so no reset.
   always_ff @(posedge clk) begin
      if (push_s && !flush) begin
         mem_r[wr_ptr_r] <= ext_s;
      end
   end

   // Occupancy and pointers; flush discards any same-edge push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r  <= {CNT_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else if (flush) begin
         count_r  <= {CNT_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Saturating illegal-op counter; survives flush, and a flushed accept
   // is treated as never having happened.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_r <= 8'd0;
      end else if (push_s && !flush && ext_s[OUT_W] && (err_cnt_r != 8'hFF)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end
   end
endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed corner cases followed by
// randomized traffic, compared against a queue-based reference model.
module tb_ext_pipe;
   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int DEPTH = 2;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic [7:0] err_cnt;

   ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .bus     (bus),
      .err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: queue of {err, data} results plus error count.
   logic [32:0] q[$];
   int          ec = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Extension computed numerically from the op definitions.
   function automatic logic [32:0] ref_ext(input int imm, input int op);
      longint s, b, sb, r;
      logic   err;
      err = 1'b0;
      s   = (imm >= 32768) ? longint'(imm) - 65536 : longint'(imm);
      b   = longint'(imm % 256);
      sb  = (b >= 128) ? b - 256 : b;
      case (op)
         0:       r = longint'(imm);
         1:       r = s;
         2:       r = longint'(imm) * 65536;
         3:       r = s * 4;
         4:       r = sb;
         5:       r = b;
         default: begin r = 0; err = 1'b1; end
      endcase
      return {err, 32'(r & 64'hFFFF_FFFF)};
   endfunction

   task automatic check_all();
      logic [32:0] head;
      head = (q.size() != 0) ? q[0] : 33'd0;
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("in_ready",  64'(bus.in_ready),  64'(q.size() < DEPTH));
      chk("out_data",  64'(bus.out_data),  64'(head[31:0]));
      chk("out_err",   64'(bus.out_err),   64'(head[32]));
      chk("err_cnt",   64'(err_cnt),       64'(ec));
   endtask

   // One clock cycle: drive inputs, advance the model, check after the edge.
   task automatic step(input bit v, input int imm, input int op, input bit ordy, input bit fl);
      bit          acc;
      bit          pp;
      logic [32:0] e;
      bus.in_valid  = v;
      bus.in_imm    = 16'(imm);
      bus.in_op     = 3'(op);
      bus.out_ready = ordy;
      flush         = fl;
      acc = v && (q.size() < DEPTH);
      pp  = ordy && (q.size() != 0);
      if (fl) begin
         q.delete();
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) begin
            e = ref_ext(imm, op);
            q.push_back(e);
            if (e[32] && ec < 255) ec++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_imm    = 16'h0;
      bus.in_op     = 3'd0;
      bus.out_ready = 1'b1;
      #1;
      check_all();
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 1, 0);

      // Extension modes, one result in flight at a time.
      step(1, 'h8001, 1, 1, 0); chk("op1_sext",  64'(bus.out_data), 64'hFFFF8001);
      chk("op1_err", 64'(bus.out_err), 64'd0);
      step(1, 'h8001, 0, 1, 0); chk("op0_zext",  64'(bus.out_data), 64'h00008001);
      step(1, 'h8001, 2, 1, 0); chk("op2_high",  64'(bus.out_data), 64'h80010000);
      step(1, 'hFFFF, 3, 1, 0); chk("op3_branch", 64'(bus.out_data), 64'hFFFFFFFC);
      step(1, 'h1280, 4, 1, 0); chk("op4_sbyte", 64'(bus.out_data), 64'hFFFFFF80);
      step(1, 'h1280, 5, 1, 0); chk("op5_zbyte", 64'(bus.out_data), 64'h00000080);
      step(0, 0, 0, 1, 0);

      // Back-pressure: fill, stall, then drain in order.
      step(1, 1, 0, 0, 0);
      step(1, 2, 0, 0, 0); chk("full_ready", 64'(bus.in_ready), 64'd0);
      step(1, 3, 0, 0, 0); chk("stall_head", 64'(bus.out_data), 64'd1);
      step(1, 3, 0, 1, 0); chk("pop_full_head", 64'(bus.out_data), 64'd2);
      chk("pop_full_ready", 64'(bus.in_ready), 64'd1);
      step(1, 3, 0, 1, 0); chk("third_head", 64'(bus.out_data), 64'd3);
      step(0, 0, 0, 1, 0); chk("drained", 64'(bus.out_valid), 64'd0);

      // Illegal ops: zero data, error flag, saturating counter.
      for (int i = 0; i < 300; i++) begin
         step(1, int'($urandom_range(0, 65535)), 7 - (i % 2), 1, 0);
         chk("illegal_err", 64'(bus.out_err), 64'd1);
      end
      chk("err_sat", 64'(err_cnt), 64'd255);
      step(0, 0, 0, 1, 1);
      chk("err_after_flush", 64'(err_cnt), 64'd255);

      // Flush with a simultaneous offer on a two-entry buffer.
      step(1, 10, 0, 0, 0);
      step(1, 11, 0, 0, 0);
      step(1, 'h77, 0, 0, 1); chk("flush_valid", 64'(bus.out_valid), 64'd0);
      step(0, 0, 0, 1, 0);    chk("flush_gone", 64'(bus.out_valid), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0);
      end

      // Asynchronous reset between edges with two entries held.
      step(0, 0, 0, 1, 1);
      step(1, 5, 0, 0, 0);
      step(1, 6, 7, 0, 0);
      chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      q.delete();
      ec = 0;
      #1;
      check_all();
      chk("async_valid", 64'(bus.out_valid), 64'd0);
      chk("async_err",   64'(err_cnt), 64'd0);
      chk("async_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 1, 0);
      step(1, 'h1234, 0, 1, 0); chk("post_rst", 64'(bus.out_data), 64'h1234);
      step(0, 0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; legal range 8 to OUT_W-2.
REQ-002 Parameter OUT_W, default 32, extended result width.
REQ-003 Parameter DEPTH, default 2, output buffer entries; legal values 2, 4 and 8.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 flush  input  1  synchronous buffer clear, active-high.
REQ-007 in_valid  input  1  producer offers in_imm and in_op this cycle.
REQ-008 in_ready  output  1  block accepts an offer this cycle.
REQ-009 in_imm  input  IN_W  raw immediate field.
REQ-010 in_op  input  3  extension mode.
REQ-011 out_valid  output  1  buffer head holds a result.
REQ-012 out_ready  input  1  consumer takes the head this cycle.
REQ-013 out_data  output  OUT_W  head result.
REQ-014 out_err  output  1  head result came from an illegal in_op.
REQ-015 err_cnt  output  8  count of accepted illegal ops.

Function
REQ-016 Accept: in_valid and in_ready both high at a rising edge; result computed combinationally from in_imm and in_op, written to buffer tail at that edge.
REQ-017 Pop: out_valid and out_ready both high at a rising edge; head entry removed.
REQ-018 in_ready = (count < DEPTH); no combinational dependence on out_ready or in_valid.
REQ-019 out_valid = (count != 0); out_data and out_err driven only from buffer head, never from the input bypass.
REQ-020 Latency: result accepted at edge N visible on out_data/out_valid after edge N, i.e. in cycle N+1 when the buffer was empty.
REQ-021 Order: results leave in acceptance order; pointers wrap modulo DEPTH.
REQ-022 op 000: zero-extend in_imm to OUT_W.
REQ-023 op 001: sign-extend in_imm (bit IN_W-1) to OUT_W.
REQ-024 op 010: in_imm in the top IN_W bits, low OUT_W-IN_W bits zero.
REQ-025 op 011: sign-extend in_imm, then shift left by 2, truncated to OUT_W (branch offset).
REQ-026 op 100: sign-extend in_imm[7:0] to OUT_W.
REQ-027 op 101: zero-extend in_imm[7:0] to OUT_W.
REQ-028 op 110, 111: illegal; out_data entry 0, out_err entry 1; all legal ops store out_err 0.
REQ-029 err_cnt increments by 1 per accepted illegal op; saturates at 255; unaffected by flush.
REQ-030 Push and pop in the same edge: count unchanged, both take effect.
REQ-031 Pop when full: in_ready stays 0 that cycle; a new accept is possible from the next cycle.
REQ-032 flush high at an edge: count and both pointers cleared, any same-edge accept or pop discarded; out_valid 0 next cycle.
REQ-033 Buffer contents of unoccupied entries are don't-care but out_data is 0 whenever out_valid is 0.

Reset
REQ-034 rst_n low: count, pointers and err_cnt cleared immediately without a clock edge; out_valid 0, out_data 0, out_err 0, in_ready 1.
REQ-035 Reset mid-transfer drops all buffered entries; first accept after release behaves as from empty.
REQ-036 rst_n release is sampled synchronously; no accept on the edge where rst_n rises.

Verification
REQ-037 Defaults, out_ready=1: in_imm=16'h8001, op 001 -> next cycle out_data=32'hFFFF8001, out_err=0; op 000 -> 32'h00008001; op 010 -> 32'h80010000.
REQ-038 op 011 with in_imm=16'hFFFF -> out_data=32'hFFFFFFFC; op 100 with in_imm=16'h1280 -> 32'hFFFFFF80; op 101 -> 32'h00000080.
REQ-039 out_ready=0, three offers of op 000 with 1,2,3 -> in_ready 0 after two accepts; raise out_ready -> results 1,2,3 in order, third accepted only after first pop.
REQ-040 300 consecutive op 111 accepts -> every output out_data=0, out_err=1, err_cnt stops at 255; flush then leaves err_cnt at 255.
REQ-041 Buffer holding 2 entries, flush asserted together with in_valid -> out_valid 0 next cycle, offered value never appears.
REQ-042 rst_n pulled low between edges with 2 entries buffered -> out_valid, err_cnt drop to 0 before the next edge; in_ready 1.
